// File: rtl/hv_am_search.sv
// Associative-memory search: streams class prototypes, returns nearest class by Hamming distance.
// Optional reject flag against a distance threshold is enabled with HV_AM_THRESHOLD_EN.
//
// state  | meaning
// IDLE   | waiting for a query from the encoder
// SEARCH | issuing prototype reads and comparing returned data
// DONE   | result presented, waiting for consumer handshake
module hv_am_search #(
    parameter  int HVDimension    = 512,
    parameter  int NumClass       = 32,
    localparam int ClassAddrWidth = $clog2(NumClass),
    localparam int DistWidth      = $clog2(HVDimension) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [HVDimension-1:0]    qhv_i,
    input  logic                      qhv_valid_i,
    output logic                      qhv_ready_o,
    output logic                      am_busy_o,
    input  logic [ClassAddrWidth:0]   num_class_i,
    output logic                      am_rd_en_o,
    output logic [ClassAddrWidth-1:0] am_rd_addr_o,
    input  logic [HVDimension-1:0]    am_rd_data_i,
    output logic [ClassAddrWidth-1:0] predict_o,
    output logic [DistWidth-1:0]      predict_dist_o,
    output logic                      predict_valid_o,
    input  logic                      predict_ready_i
`ifdef HV_AM_THRESHOLD_EN
    ,
    input  logic [DistWidth-1:0]      dist_threshold_i,
    output logic                      predict_reject_o
`endif
);

    localparam int CntWidth = ClassAddrWidth + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e                    r_state;
    logic [HVDimension-1:0]    r_query;
    logic [CntWidth-1:0]       r_num;
    logic                      r_rd_en;
    logic [ClassAddrWidth-1:0] r_rd_addr;
    logic                      r_cmp_valid;
    logic [ClassAddrWidth-1:0] r_cmp_idx;
    logic [DistWidth-1:0]      r_min_dist;
    logic [ClassAddrWidth-1:0] r_min_idx;
    logic [ClassAddrWidth-1:0] r_predict;
    logic [DistWidth-1:0]      r_predict_dist;
    logic                      r_predict_valid;
    logic                      r_qhv_ready;

    logic [CntWidth-1:0]       w_num_clamped;
    logic [ClassAddrWidth-1:0] w_last_addr;
    logic [HVDimension-1:0]    w_xor;
    logic [DistWidth-1:0]      w_dist;
    logic                      w_better;
    logic [DistWidth-1:0]      w_min_dist_nxt;
    logic [ClassAddrWidth-1:0] w_min_idx_nxt;
    logic                      w_accept;
    logic                      w_last_cmp;
    logic                      w_consume;

    assign w_num_clamped = (num_class_i > CntWidth'(NumClass)) ? CntWidth'(NumClass) : num_class_i;
    assign w_last_addr   = ClassAddrWidth'(r_num - 1'b1);
    assign w_xor         = r_query ^ am_rd_data_i;

    always_comb begin
        w_dist = '0;
        for (int i = 0; i < HVDimension; i++) begin
            w_dist = w_dist + DistWidth'(w_xor[i]);
        end
    end

    // Strict compare so equal distances keep the earlier (lower) index.
    assign w_better       = r_cmp_valid && (w_dist < r_min_dist);
    assign w_min_dist_nxt = w_better ? w_dist    : r_min_dist;
    assign w_min_idx_nxt  = w_better ? r_cmp_idx : r_min_idx;

    assign w_accept   = (r_state == IDLE) && r_qhv_ready && qhv_valid_i;
    assign w_last_cmp = (r_state == SEARCH) && r_cmp_valid && (r_cmp_idx == w_last_addr);
    assign w_consume  = (r_state == DONE) && predict_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= IDLE;
            r_query         <= '0;
            r_num           <= '0;
            r_rd_en         <= 1'b0;
            r_rd_addr       <= '0;
            r_cmp_valid     <= 1'b0;
            r_cmp_idx       <= '0;
            r_min_dist      <= '0;
            r_min_idx       <= '0;
            r_predict       <= '0;
            r_predict_dist  <= '0;
            r_predict_valid <= 1'b0;
            r_qhv_ready     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_qhv_ready <= 1'b1;
                    if (w_accept) begin
                        r_query     <= qhv_i;
                        r_num       <= w_num_clamped;
                        r_min_dist  <= '1;
                        r_min_idx   <= '0;
                        r_rd_addr   <= '0;
                        r_qhv_ready <= 1'b0;
                        if (w_num_clamped == '0) begin
                            r_state         <= DONE;
                            r_predict       <= '0;
                            r_predict_dist  <= '1;
                            r_predict_valid <= 1'b1;
                        end else begin
                            r_state <= SEARCH;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    r_cmp_valid <= r_rd_en;
                    r_cmp_idx   <= r_rd_addr;
                    if (r_rd_en) begin
                        if (r_rd_addr == w_last_addr) begin
                            r_rd_en <= 1'b0;
                        end else begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end
                    end
                    if (r_cmp_valid) begin
                        r_min_dist <= w_min_dist_nxt;
                        r_min_idx  <= w_min_idx_nxt;
                    end
                    if (w_last_cmp) begin
                        r_state         <= DONE;
                        r_predict       <= w_min_idx_nxt;
                        r_predict_dist  <= w_min_dist_nxt;
                        r_predict_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (w_consume) begin
                        r_state         <= IDLE;
                        r_predict_valid <= 1'b0;
                        r_qhv_ready     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef HV_AM_THRESHOLD_EN
    logic [DistWidth-1:0] r_thresh;
    logic                 r_reject;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_thresh <= '0;
            r_reject <= 1'b0;
        end else if (w_accept) begin
            r_thresh <= dist_threshold_i;
            r_reject <= (w_num_clamped == '0);
        end else if (w_last_cmp) begin
            r_reject <= (w_min_dist_nxt > r_thresh);
        end else if (w_consume) begin
            r_reject <= 1'b0;
        end
    end

    assign predict_reject_o = r_reject;
`else
    // No reject path in this build; results are always reported as-is.
`endif

    assign qhv_ready_o     = r_qhv_ready;
    assign am_busy_o       = (r_state != IDLE);
    assign am_rd_en_o      = r_rd_en;
    assign am_rd_addr_o    = r_rd_addr;
    assign predict_o       = r_predict;
    assign predict_dist_o  = r_predict_dist;
    assign predict_valid_o = r_predict_valid;

endmodule

// File: tb/tb_hv_am_search.sv
// Directed self-checking bench for hv_am_search; threshold cases compile in with HV_AM_THRESHOLD_EN.
module tb_hv_am_search;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [511:0] qhv_i;
    logic         qhv_valid_i;
    logic         qhv_ready_o;
    logic         am_busy_o;
    logic [5:0]   num_class_i;
    logic         am_rd_en_o;
    logic [4:0]   am_rd_addr_o;
    logic [511:0] am_rd_data_i = '0;
    logic [4:0]   predict_o;
    logic [9:0]   predict_dist_o;
    logic         predict_valid_o;
    logic         predict_ready_i;
`ifdef HV_AM_THRESHOLD_EN
    logic [9:0]   dist_threshold_i;
    logic         predict_reject_o;
`endif

    logic [511:0] mem [32];
    int total = 0;
    int bad = 0;

    hv_am_search dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .qhv_i           (qhv_i),
        .qhv_valid_i     (qhv_valid_i),
        .qhv_ready_o     (qhv_ready_o),
        .am_busy_o       (am_busy_o),
        .num_class_i     (num_class_i),
        .am_rd_en_o      (am_rd_en_o),
        .am_rd_addr_o    (am_rd_addr_o),
        .am_rd_data_i    (am_rd_data_i),
        .predict_o       (predict_o),
        .predict_dist_o  (predict_dist_o),
        .predict_valid_o (predict_valid_o),
        .predict_ready_i (predict_ready_i)
`ifdef HV_AM_THRESHOLD_EN
        ,
        .dist_threshold_i(dist_threshold_i),
        .predict_reject_o(predict_reject_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Prototype memory with one cycle of read latency.
    always @(posedge clk_i) begin
        if (am_rd_en_o) am_rd_data_i <= mem[am_rd_addr_o];
    end

    function automatic logic [511:0] ones(input int n);
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) tick();
        total++;
        if ({predict_valid_o, am_rd_en_o, am_busy_o, qhv_ready_o} !== 4'b0000 ||
            predict_o !== 5'd0 || predict_dist_o !== 10'd0 || am_rd_addr_o !== 5'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b rd=%b busy=%b rdy=%b p=%0d d=%0d, want all 0",
                     predict_valid_o, am_rd_en_o, am_busy_o, qhv_ready_o, predict_o, predict_dist_o);
        end
        rst_ni = 1'b1;
        tick();
        total++;
        if (qhv_ready_o !== 1'b1 || am_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got rdy=%b busy=%b, want rdy=1 busy=0", qhv_ready_o, am_busy_o);
        end
    endtask

    task automatic test_tie();
        mem[0] = ones(100); mem[1] = ones(37); mem[2] = ones(200); mem[3] = ones(37);
        qhv_i = '0; num_class_i = 6'd4; qhv_valid_i = 1'b1;
        tick();
        qhv_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (am_rd_en_o !== 1'b1 || am_rd_addr_o !== 5'(k) || predict_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL tie_issue%0d: got en=%b addr=%0d v=%b, want en=1 addr=%0d v=0",
                         k, am_rd_en_o, am_rd_addr_o, predict_valid_o, k);
            end
            tick();
        end
        total++;
        if (am_rd_en_o !== 1'b0 || predict_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL tie_t5: got en=%b v=%b, want 0 0", am_rd_en_o, predict_valid_o);
        end
        tick();
        total++;
        if (predict_valid_o !== 1'b1 || predict_o !== 5'd1 || predict_dist_o !== 10'd37 ||
            am_busy_o !== 1'b1 || qhv_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL tie_result: got v=%b p=%0d d=%0d busy=%b rdy=%b, want 1 1 37 1 0",
                     predict_valid_o, predict_o, predict_dist_o, am_busy_o, qhv_ready_o);
        end
        predict_ready_i = 1'b1;
        tick();
        predict_ready_i = 1'b0;
        total++;
        if (predict_valid_o !== 1'b0 || qhv_ready_o !== 1'b1 || am_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL tie_consume: got v=%b rdy=%b busy=%b, want 0 1 0",
                     predict_valid_o, qhv_ready_o, am_busy_o);
        end
    endtask

    task automatic test_match_complement();
        logic [511:0] q;
        q = {16{32'hA5C3_961E}};
        mem[0] = ~q; mem[1] = q ^ ones(3); mem[2] = q; mem[3] = q ^ ones(1);
        for (int k = 4; k < 8; k++) mem[k] = q ^ ones(k + 2);
        qhv_i = q; num_class_i = 6'd8; qhv_valid_i = 1'b1;
        tick();
        qhv_valid_i = 1'b0;
        repeat (8) tick();
        total++;
        if (predict_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL match_early: got v=%b at T+9, want 0", predict_valid_o);
        end
        tick();
        total++;
        if (predict_valid_o !== 1'b1 || predict_o !== 5'd2 || predict_dist_o !== 10'd0) begin
            bad++;
            $display("FAIL match_result: got v=%b p=%0d d=%0d, want 1 2 0",
                     predict_valid_o, predict_o, predict_dist_o);
        end
        predict_ready_i = 1'b1;
        tick();
        predict_ready_i = 1'b0;
        // Single complement prototype: full-width distance.
        num_class_i = 6'd1; qhv_valid_i = 1'b1;
        tick();
        qhv_valid_i = 1'b0;
        repeat (2) tick();
        total++;
        if (predict_valid_o !== 1'b1 || predict_o !== 5'd0 || predict_dist_o !== 10'd512) begin
            bad++;
            $display("FAIL complement_dist: got v=%b p=%0d d=%0d, want 1 0 512",
                     predict_valid_o, predict_o, predict_dist_o);
        end
        predict_ready_i = 1'b1;
        tick();
        predict_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        mem[0] = ones(10); mem[1] = ones(5);
        qhv_i = '0; num_class_i = 6'd2; qhv_valid_i = 1'b1;
        tick();
        // Second query pending for the whole first transaction.
        qhv_i = ones(10);
        repeat (2) tick();
        total++;
        if (predict_valid_o !== 1'b0 || qhv_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_t3: got v=%b rdy=%b, want 0 0", predict_valid_o, qhv_ready_o);
        end
        tick();
        for (int c = 0; c < 5; c++) begin
            total++;
            if (predict_valid_o !== 1'b1 || predict_o !== 5'd1 || predict_dist_o !== 10'd5 ||
                qhv_ready_o !== 1'b0 || am_busy_o !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold%0d: got v=%b p=%0d d=%0d rdy=%b busy=%b, want 1 1 5 0 1",
                         c, predict_valid_o, predict_o, predict_dist_o, qhv_ready_o, am_busy_o);
            end
            tick();
        end
        predict_ready_i = 1'b1;
        tick();
        predict_ready_i = 1'b0;
        total++;
        if (qhv_ready_o !== 1'b1 || predict_valid_o !== 1'b0 || am_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_bubble: got rdy=%b v=%b busy=%b, want 1 0 0",
                     qhv_ready_o, predict_valid_o, am_busy_o);
        end
        tick();
        qhv_valid_i = 1'b0;
        total++;
        if (am_rd_en_o !== 1'b1 || am_rd_addr_o !== 5'd0 || am_busy_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_accept2: got en=%b addr=%0d busy=%b, want 1 0 1",
                     am_rd_en_o, am_rd_addr_o, am_busy_o);
        end
        repeat (3) tick();
        total++;
        if (predict_valid_o !== 1'b1 || predict_o !== 5'd0 || predict_dist_o !== 10'd0) begin
            bad++;
            $display("FAIL bp_result2: got v=%b p=%0d d=%0d, want 1 0 0",
                     predict_valid_o, predict_o, predict_dist_o);
        end
        predict_ready_i = 1'b1;
        tick();
        predict_ready_i = 1'b0;
    endtask

    task automatic test_zero_class();
        qhv_i = ones(7); num_class_i = 6'd0; qhv_valid_i = 1'b1;
`ifdef HV_AM_THRESHOLD_EN
        dist_threshold_i = 10'd1023;
`endif
        tick();
        qhv_valid_i = 1'b0;
        total++;
        if (am_rd_en_o !== 1'b0 || predict_valid_o !== 1'b1 || predict_o !== 5'd0 ||
            predict_dist_o !== 10'h3FF) begin
            bad++;
            $display("FAIL zero_result: got en=%b v=%b p=%0d d=%0d, want 0 1 0 1023",
                     am_rd_en_o, predict_valid_o, predict_o, predict_dist_o);
        end
`ifdef HV_AM_THRESHOLD_EN
        total++;
        if (predict_reject_o !== 1'b1) begin
            bad++;
            $display("FAIL zero_reject: got %b, want 1", predict_reject_o);
        end
`endif
        predict_ready_i = 1'b1;
        tick();
        predict_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 16; k++) mem[k] = ones(k + 20);
        qhv_i = '0; num_class_i = 6'd16; qhv_valid_i = 1'b1;
        tick();
        qhv_valid_i = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b0;
        #1;
        total++;
        if ({predict_valid_o, am_rd_en_o, am_busy_o, qhv_ready_o} !== 4'b0000 ||
            am_rd_addr_o !== 5'd0 || predict_o !== 5'd0 || predict_dist_o !== 10'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got v=%b en=%b busy=%b rdy=%b addr=%0d, want all 0",
                     predict_valid_o, am_rd_en_o, am_busy_o, qhv_ready_o, am_rd_addr_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
        mem[0] = ones(3); mem[1] = ones(2);
        qhv_i = '0; num_class_i = 6'd2; qhv_valid_i = 1'b1;
        tick();
        qhv_valid_i = 1'b0;
        total++;
        if (am_rd_en_o !== 1'b1 || am_rd_addr_o !== 5'd0) begin
            bad++;
            $display("FAIL midreset_issue0: got en=%b addr=%0d, want 1 0", am_rd_en_o, am_rd_addr_o);
        end
        tick();
        total++;
        if (am_rd_en_o !== 1'b1 || am_rd_addr_o !== 5'd1) begin
            bad++;
            $display("FAIL midreset_issue1: got en=%b addr=%0d, want 1 1", am_rd_en_o, am_rd_addr_o);
        end
        tick();
        total++;
        if (predict_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL midreset_early: got v=%b, want 0", predict_valid_o);
        end
        tick();
        total++;
        if (predict_valid_o !== 1'b1 || predict_o !== 5'd1 || predict_dist_o !== 10'd2) begin
            bad++;
            $display("FAIL midreset_result: got v=%b p=%0d d=%0d, want 1 1 2",
                     predict_valid_o, predict_o, predict_dist_o);
        end
        predict_ready_i = 1'b1;
        tick();
        predict_ready_i = 1'b0;
    endtask

`ifdef HV_AM_THRESHOLD_EN
    task automatic test_threshold();
        mem[0] = ones(51);
        for (int t = 50; t <= 51; t++) begin
            qhv_i = '0; num_class_i = 6'd1; dist_threshold_i = 10'(t); qhv_valid_i = 1'b1;
            tick();
            qhv_valid_i = 1'b0;
            repeat (2) tick();
            total++;
            if (predict_valid_o !== 1'b1 || predict_dist_o !== 10'd51 ||
                predict_reject_o !== ((t == 50) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL thresh_%0d: got v=%b d=%0d rej=%b, want 1 51 %0d",
                         t, predict_valid_o, predict_dist_o, predict_reject_o, (t == 50) ? 1 : 0);
            end
            predict_ready_i = 1'b1;
            tick();
            predict_ready_i = 1'b0;
        end
    endtask
`endif

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = '0;
        qhv_i = '0;
        qhv_valid_i = 1'b0;
        num_class_i = '0;
        predict_ready_i = 1'b0;
`ifdef HV_AM_THRESHOLD_EN
        dist_threshold_i = '0;
`endif
        test_reset();
        test_tie();
        test_match_complement();
        test_backpressure();
        test_zero_class();
        test_reset_mid();
`ifdef HV_AM_THRESHOLD_EN
        test_threshold();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hv_am_search.md
Name: hv_am_search

Overview:
- Associative-memory search stage directly downstream of the hypervector encoder.
- Accepts the encoder's query HV over a valid/ready handshake and drives the encoder's AM-busy input.
- Streams class prototype HVs from an external prototype memory (1-cycle read latency) and computes the Hamming distance of each prototype to the query.
- Returns the index and distance of the nearest class over a valid/ready result handshake.

Parameters:
- HVDimension, 512, hypervector width in bits.
- NumClass, 32, maximum number of class prototypes.
- ClassAddrWidth, $clog2(NumClass), prototype address and predicted-index width (derived, do not override).
- DistWidth, $clog2(HVDimension)+1, Hamming distance width; holds the value HVDimension (derived).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous and active-low.
- qhv_i  in  HVDimension  query HV from encoder.
- qhv_valid_i  in  1  query valid.
- qhv_ready_o  out  1  query accepted when high together with qhv_valid_i.
- am_busy_o  out  1  search in progress or result pending; feeds encoder AM-busy input.
- num_class_i  in  ClassAddrWidth+1  number of prototypes to search; sampled at query accept.
- am_rd_en_o  out  1  prototype memory read enable.
- am_rd_addr_o  out  ClassAddrWidth  prototype memory address.
- am_rd_data_i  in  HVDimension  prototype data; valid exactly 1 cycle after am_rd_en_o.
- predict_o  out  ClassAddrWidth  index of nearest class.
- predict_dist_o  out  DistWidth  Hamming distance of nearest class.
- predict_valid_o  out  1  result valid.
- predict_ready_i  in  1  result consumed when high together with predict_valid_o.

Behaviour:
- FSM states: IDLE, SEARCH, DONE. All outputs reset to 0; FSM resets to IDLE. Query register, minimum tracker and counters reset to 0.
- IDLE:
  - qhv_ready_o=1, am_busy_o=0.
  - On handshake at cycle T: latch qhv_i and num_class_i (N), clear issue counter, set min_dist to all ones and min_idx to 0.
  - N>0: go to SEARCH. N==0: go to DONE with predict_o=0 and predict_dist_o=all ones.
  - N>NumClass: clamp to NumClass.
- SEARCH:
  - am_rd_en_o=1 with am_rd_addr_o=k for k=0..N-1, in cycles T+1..T+N.
  - A registered compare stage takes am_rd_data_i in cycles T+2..T+N+1.
  - dist = popcount(query XOR data), zero-extended to DistWidth.
  - Update the minimum only if dist < min_dist (strict), so ties keep the lowest index.
  - am_rd_en_o drops after the last issue. The FSM moves to DONE once the final compare completes.
- DONE:
  - predict_valid_o=1 from cycle T+N+2; total latency is N+2 cycles from query accept to result valid.
  - predict_o and predict_dist_o are held stable while predict_valid_o && !predict_ready_i.
  - On handshake, go to IDLE. The earliest next query accept is the following cycle (one-cycle bubble).
- am_busy_o = (state != IDLE); qhv_ready_o = (state == IDLE).
- Back-pressure: a query presented while busy stays pending upstream. This block never drops or overwrites a latched query.
- Reset mid-search or mid-DONE: immediate return to IDLE; outputs 0; partial results discarded.
- Distance boundaries:
  - Identical HVs: dist=0.
  - Bitwise complement: dist=HVDimension, which must not overflow DistWidth.
- predict_valid_o, am_rd_en_o and qhv_ready_o are never high simultaneously with an inconsistent state.

Optional Feature:
- Macro: HV_AM_THRESHOLD_EN.
- Defined:
  - Adds port dist_threshold_i (in, DistWidth), sampled at query accept.
  - Adds port predict_reject_o (out, 1). It is valid alongside predict_valid_o and set when final predict_dist_o > threshold.
  - Reset value 0. For N==0, reject=1.
- Undefined: neither port exists; no reject logic.

Test Plan:
- Reset, then N=4 prototypes with distances {100,37,200,37}: accept at T -> reads at T+1..T+4 for addresses 0..3, predict_valid_o at T+6, predict_o=1, dist=37 (tie keeps lowest index).
- Query equals prototype 2 of 8; prototype 0 is the bitwise complement -> predict_o=2, dist=0; complement case computes dist=512 without overflow.
- Hold predict_ready_i=0 for 5 cycles after valid, with a second query valid throughout -> outputs stable, qhv_ready_o=0, am_busy_o=1; after the ready pulse, the second query is accepted the next cycle.
- num_class_i=0 -> predict_valid_o 1 cycle after accept, predict_o=0, dist=all ones, no am_rd_en_o pulses.
- Assert rst_ni low at T+3 of an N=16 search -> all outputs 0 immediately, FSM back in IDLE; a fresh N=2 query then completes correctly in 4 cycles.
- With HV_AM_THRESHOLD_EN: threshold=50, best dist=51 -> predict_reject_o=1; with threshold=51 -> predict_reject_o=0.
